junction_cycle_sequencer: RTL
=============================

Name: junction_cycle_sequencer

Overview:
- Upstream driver of the z-way DRP interleaver set.
- Per junction pass, generates the cycle_index sweep 0..C-1, where C = fo*p/z.
- Honours downstream backpressure and emits valid/last strobes, delayed to match the address-to-data pipeline.
- Signals done once the final cycle has drained, so the layer controller can start the next junction.

Parameters:
- fo, 2, fan-out of the junction
- p, 16, neurons on the junction's input side
- z, 8, parallel weights processed per cycle; fo*p must be a multiple of z
- PIPE_LAT, 2, downstream latency in cycles from cycle_index to gathered data; 1..8
- C (localparam), fo*p/z, cycles per junction; CW = max(1, $clog2(C))

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request one junction pass; sampled only in IDLE
- ready  in  1  downstream accepts the current cycle_index this clock
- cycle_index  out  CW  drives the interleaver set
- cyc_valid  out  1  cycle_index is meaningful
- cyc_last  out  1  cycle_index == C-1 and cyc_valid
- dly_valid  out  1  cyc_valid&&ready delayed by PIPE_LAT
- dly_last  out  1  accepted cyc_last delayed by PIPE_LAT
- dly_index  out  CW  accepted cycle_index delayed by PIPE_LAT
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high: every register clears on the clk edge where reset=1.
- Reset values:
  - cycle_index=0, cyc_valid=0, cyc_last=0
  - dly_* = 0, delay line flushed
  - busy=0, done=0, state=IDLE
- State IDLE:
  - cyc_valid=0.
  - start=1 -> RUN on the next edge, with cycle_index=0.
- State RUN:
  - cyc_valid=1.
  - On valid&&ready:
    - If cycle_index<C-1: cycle_index+1.
    - If cycle_index==C-1: cycle_index wraps to 0, state -> DRAIN, drain counter loaded with PIPE_LAT-1.
  - ready=0 holds cycle_index and state; there is no timeout.
- State DRAIN:
  - cyc_valid=0; counter decrements each cycle.
  - At 0: done=1 for exactly that cycle, state -> IDLE.
  - Timing: done asserts in the same cycle dly_last=1, i.e. PIPE_LAT cycles after the final acceptance.
- start is ignored outside IDLE; it is not queued.
- Delay line:
  - PIPE_LAT-deep shift of {valid&&ready, last&&ready, cycle_index}.
  - Free-running: not stalled by ready, since the downstream pipe is not stalled.
  - Stalled cycles insert bubbles (dly_valid=0).
- C==1: CW=1, cycle_index stays 0, cyc_last=1 on the only cycle.
- Reset mid-RUN or mid-DRAIN: immediate return to IDLE, no done pulse, delay line cleared.
- Combinational paths:
  - cyc_last, busy and cyc_valid are combinational from state/count.
  - No combinational path from ready or start to any output.

Optional Feature:
- Macro JCS_BACK_TO_BACK_EN.
- Defined:
  - In RUN, if start=1 in the cycle the final index is accepted, the sequencer stays in RUN with cycle_index=0 next cycle, skipping DRAIN.
  - done still pulses, timed by a PIPE_LAT-deep shift of the final-accept event.
  - Overlapping passes each produce their own done pulse.
- Undefined:
  - start during RUN is ignored.
  - Minimum spacing between passes is C+PIPE_LAT+1 cycles.

Decomposition:
- Shared package dnn_pkg holds:
  - the state enum {IDLE, RUN, DRAIN}
  - a function computing C and CW from fo, p, z
  - PIPE_LAT bounds
- One natural sub-module: valid_delay_line (parameterised width/depth shift register with synchronous clear), reused for the dly_* outputs and the JCS_BACK_TO_BACK_EN done timing.

Test Plan:
All scenarios use defaults fo=2, p=16, z=8 (C=4, CW=2), PIPE_LAT=2.
1. reset high 3 cycles, then low, start=0 -> all outputs 0, busy=0 indefinitely.
2. start pulse, ready=1 -> cycle_index 0,1,2,3 on consecutive cycles with cyc_valid=1, cyc_last only on index 3; dly_index 0..3 two cycles later; done pulses once, in the dly_last cycle; busy falls after done.
3. start, ready=0 for 3 cycles at index 1 -> index held at 1; dly_valid shows 3 bubbles; total pass = 4+3 stall+2 drain cycles; done single pulse.
4. start asserted again during RUN and DRAIN -> ignored, exactly one pass (4 accepted indices) per IDLE start.
5. reset asserted during DRAIN -> next cycle IDLE, done never pulses, dly_valid=0; a subsequent start runs a clean pass from 0.
6. JCS_BACK_TO_BACK_EN defined, start held 1 -> index sequence 0,1,2,3,0,1,2,3 with no gap, two done pulses 4 cycles apart.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared types and helpers for the junction sequencing blocks: FSM state,
// cycles-per-junction arithmetic and the supported downstream latency range.
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } jcs_state_t;

  localparam int PIPE_LAT_MIN = 1;
  localparam int PIPE_LAT_MAX = 8;
  // Wide enough for the largest drain preload, PIPE_LAT_MAX-1.
  localparam int DRAIN_CW = $clog2(PIPE_LAT_MAX);

  function automatic int calc_cycles(input int fo, input int p, input int z);
    return (fo * p) / z;
  endfunction

  function automatic int calc_cw(input int fo, input int p, input int z);
    int c;
    c = calc_cycles(fo, p, z);
    return (c <= 1) ? 1 : $clog2(c);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Free-running W-bit x D-stage shift register with synchronous clear; used to
// align strobes and indices with the downstream address-to-data pipeline.
module valid_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar gi = 0; gi < D; gi++) begin : g_stage
    logic [W-1:0] q_reg;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset) q_reg <= '0;
        else       q_reg <= din;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (reset) q_reg <= '0;
        else       q_reg <= g_stage[gi-1].q_reg;
      end
    end
  end

  assign dout = g_stage[D-1].q_reg;

endmodule

// File: rtl/junction_cycle_sequencer.sv
// Generates the 0..C-1 cycle_index sweep for one junction pass, with delayed
// strobes and a done pulse. Optional feature macro: JCS_BACK_TO_BACK_EN.
module junction_cycle_sequencer
  import dnn_pkg::*;
#(
  parameter int fo       = 2,
  parameter int p        = 16,
  parameter int z        = 8,
  parameter int PIPE_LAT = 2,
  localparam int C       = calc_cycles(fo, p, z),
  localparam int CW      = calc_cw(fo, p, z)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ready,
  output logic [CW-1:0] cycle_index,
  output logic          cyc_valid,
  output logic          cyc_last,
  output logic          dly_valid,
  output logic          dly_last,
  output logic [CW-1:0] dly_index,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0]       LAST_IDX   = CW'(C - 1);
  localparam logic [DRAIN_CW-1:0] DRAIN_LOAD = DRAIN_CW'(PIPE_LAT - 1);

  jcs_state_t          state_reg, state_next;
  logic [CW-1:0]       idx_reg, idx_next;
  logic [DRAIN_CW-1:0] cnt_reg, cnt_next;
  logic                accept;
  logic [CW+1:0]       line_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      RUN: begin
        if (ready) begin
          if (idx_reg == LAST_IDX) begin
            idx_next = '0;
`ifdef JCS_BACK_TO_BACK_EN
            // A start coinciding with the final accept chains straight into the next pass.
            if (!start) begin
              state_next = DRAIN;
              cnt_next   = DRAIN_LOAD;
            end
`else
            state_next = DRAIN;
            cnt_next   = DRAIN_LOAD;
`endif
          end else begin
            idx_next = idx_reg + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - DRAIN_CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef JCS_BACK_TO_BACK_EN
  logic done_dly;

  valid_delay_line #(.W(1), .D(PIPE_LAT)) u_done_line (
    .clk   (clk),
    .reset (reset),
    .din   (accept & cyc_last),
    .dout  (done_dly)
  );
`endif

  always_comb begin
    cyc_valid = (state_reg == RUN);
    cyc_last  = (state_reg == RUN) && (idx_reg == LAST_IDX);
    busy      = (state_reg != IDLE);
`ifdef JCS_BACK_TO_BACK_EN
    done      = done_dly;
`else
    done      = (state_reg == DRAIN) && (cnt_reg == '0);
`endif
  end

  assign cycle_index = idx_reg;
  assign accept      = cyc_valid & ready;

  valid_delay_line #(.W(CW + 2), .D(PIPE_LAT)) u_dly_line (
    .clk   (clk),
    .reset (reset),
    .din   ({accept, cyc_last & ready, idx_reg}),
    .dout  (line_out)
  );

  assign {dly_valid, dly_last, dly_index} = line_out;

endmodule
